// File: rtl/divmmc_pkg.sv
// DivMMC SPI arbiter shared types.
// Owner-state encoding, gap default and SPI idle byte.
package divmmc_pkg;

   typedef enum logic [1:0] {
      OWN_A    = 2'd0,
      GAP_TO_B = 2'd1,
      OWN_B    = 2'd2,
      GAP_TO_A = 2'd3
   } owner_t;

   localparam int         GAP_CE_DEF = 2;
   localparam logic [7:0] SPI_IDLE   = 8'hFF;

endpackage

// File: rtl/divmmc_spi_shift.sv
// SPI byte shifter: 16 half-bit steps per byte, MSB first.
// Idle when count[4]=1; the shift register keeps the last byte received.
module divmmc_spi_shift
   import divmmc_pkg::*;
(
   input  logic       clk_sys,
   input  logic       reset_n,
   input  logic       i_spi_ce,
   input  logic       i_start,
   input  logic [7:0] i_load,
   output logic       o_busy,
   output logic       o_done,
   output logic [7:0] o_rx,
   output logic       o_spi_clk,
   output logic       o_spi_do,
   input  logic       i_spi_di
);

   logic [4:0] r_count;
   logic [7:0] r_shift;
   logic       r_done;

   // Half-bit counter and shift register; saturates at 16 (idle).
   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         r_count <= 5'h10;
         r_shift <= SPI_IDLE;
      end else if (i_start) begin
         r_count <= 5'h00;
         r_shift <= i_load;
      end else if (i_spi_ce && !r_count[4]) begin
         if (r_count[0])
            r_shift <= {r_shift[6:0], i_spi_di};
         r_count <= r_count + 5'd1;
      end
   end

   // Completion pulse, aligned with the received byte being in r_shift.
   always_ff @(posedge clk_sys) begin
      if (!reset_n)
         r_done <= 1'b0;
      else
         r_done <= i_spi_ce & (r_count == 5'd15);
   end

   assign o_busy    = ~r_count[4];
   assign o_done    = r_done;
   assign o_rx      = r_shift;
   assign o_spi_clk = r_count[0];
   assign o_spi_do  = r_shift[7];

endmodule

// File: rtl/divmmc_spi_arb.sv
// Arbitrates the SD card SPI between the DivMMC CPU port (A)
// and the hardware loader (B), with a deselect gap on handover.
module divmmc_spi_arb
   import divmmc_pkg::*;
#(
   parameter int GAP_CE = GAP_CE_DEF,
   parameter bit B_PRIO = 1'b0
) (
   input  logic       clk_sys,
   input  logic       reset_n,
   input  logic       spi_ce,
   input  logic       a_ss,
   input  logic       a_tx,
   input  logic       a_rx,
   input  logic [7:0] a_din,
   output logic [7:0] a_dout,
   output logic       a_ready,
   input  logic       b_req,
   output logic       b_gnt,
   input  logic       b_ss,
   input  logic       b_tx,
   input  logic [7:0] b_din,
   output logic [7:0] b_dout,
   output logic       b_valid,
   output logic       b_busy,
   output logic       spi_ss,
   output logic       spi_clk,
   output logic       spi_do,
   input  logic       spi_di
);

   localparam logic [7:0] GAP_LAST = 8'(GAP_CE - 1);

   owner_t     r_state;
   owner_t     w_state_n;
   logic [7:0] r_gap;
   logic       r_pend;
   logic [7:0] r_pend_byte;
   logic       r_xfer_b;
   logic [7:0] r_a_dout;
   logic [7:0] r_b_dout;
   logic       r_b_valid;
   logic       r_b_busy;
   logic       r_spi_ss;

   logic       w_busy;
   logic       w_done;
   logic [7:0] w_rx;
   logic       w_start;
   logic [7:0] w_load;
   logic       w_a_new;
   logic       w_a_req;
   logic [7:0] w_a_byte;
   logic       w_a_start;
   logic       w_a_latch;
   logic       w_b_start;
   logic       w_go_b;
   logic       w_go_a;
   logic       w_in_gap;
   logic       w_gap_end;
   logic       w_ss_n;

   assign w_a_new   = a_tx | a_rx;
   assign w_a_req   = r_pend | w_a_new;
   assign w_a_byte  = r_pend ? r_pend_byte :
                      (a_tx ? a_din : SPI_IDLE);
   assign w_in_gap  = (r_state == GAP_TO_B) |
                      (r_state == GAP_TO_A);
   assign w_gap_end = w_in_gap & spi_ce &
                      (r_gap == GAP_LAST);

   // A strobe in the handover cycle is latched, not started.
   assign w_go_b = (r_state == OWN_A) & b_req & a_ss &
                   ~w_busy & (~w_a_req | B_PRIO);
   // B keeps the bus until its b_valid cycle has passed.
   assign w_go_a = (r_state == OWN_B) & ~b_req & b_ss &
                   ~w_busy & ~r_b_busy & ~b_tx;

   assign w_a_start = (r_state == OWN_A) & ~w_busy &
                      w_a_req & ~w_go_b;
   assign w_b_start = (r_state == OWN_B) & ~w_busy & b_tx;
   assign w_a_latch = w_a_new & ~r_pend &
                      ((r_state != OWN_A) | w_go_b);

   assign w_start = w_a_start | w_b_start;
   assign w_load  = w_a_start ? w_a_byte : b_din;

   divmmc_spi_shift u_shift (
      .clk_sys   (clk_sys),
      .reset_n   (reset_n),
      .i_spi_ce  (spi_ce),
      .i_start   (w_start),
      .i_load    (w_load),
      .o_busy    (w_busy),
      .o_done    (w_done),
      .o_rx      (w_rx),
      .o_spi_clk (spi_clk),
      .o_spi_do  (spi_do),
      .i_spi_di  (spi_di)
   );

   // Owner state register.
   always_ff @(posedge clk_sys) begin
      if (!reset_n)
         r_state <= OWN_A;
      else
         r_state <= w_state_n;
   end

   // Owner next-state and the select level that goes with it.
   always_comb begin
      w_state_n = r_state;
      w_ss_n    = 1'b1;
      unique case (r_state)
         OWN_A:    if (w_go_b)    w_state_n = GAP_TO_B;
         GAP_TO_B: if (w_gap_end) w_state_n = OWN_B;
         OWN_B:    if (w_go_a)    w_state_n = GAP_TO_A;
         GAP_TO_A: if (w_gap_end) w_state_n = OWN_A;
         default:                 w_state_n = OWN_A;
      endcase
      if (w_state_n == OWN_A)
         w_ss_n = a_ss;
      else if (w_state_n == OWN_B)
         w_ss_n = b_ss;
   end

   // Counts spi_ce pulses spent deselected during a handover.
   always_ff @(posedge clk_sys) begin
      if (!reset_n)
         r_gap <= 8'd0;
      else if (!w_in_gap || w_gap_end)
         r_gap <= 8'd0;
      else if (spi_ce)
         r_gap <= r_gap + 8'd1;
   end

   // Registered card select, forced high through each gap.
   always_ff @(posedge clk_sys) begin
      if (!reset_n)
         r_spi_ss <= 1'b1;
      else
         r_spi_ss <= w_ss_n;
   end

   // A side: one-deep pending strobe and pipelined read byte.
   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         r_pend      <= 1'b0;
         r_pend_byte <= SPI_IDLE;
         r_a_dout    <= SPI_IDLE;
         r_xfer_b    <= 1'b0;
      end else begin
         if (w_a_start) begin
            r_pend   <= 1'b0;
            r_a_dout <= w_rx;
         end else if (w_a_latch) begin
            r_pend      <= 1'b1;
            r_pend_byte <= a_tx ? a_din : SPI_IDLE;
         end
         if (w_start)
            r_xfer_b <= w_b_start;
      end
   end

   // B side: result capture, valid pulse and busy window.
   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         r_b_valid <= 1'b0;
         r_b_dout  <= SPI_IDLE;
         r_b_busy  <= 1'b0;
      end else begin
         r_b_valid <= w_done & r_xfer_b;
         if (w_done && r_xfer_b)
            r_b_dout <= w_rx;
         if (w_b_start)
            r_b_busy <= 1'b1;
         else if (r_b_valid)
            r_b_busy <= 1'b0;
      end
   end

   assign a_dout  = r_a_dout;
   assign a_ready = ~r_pend & ~(w_busy & ~r_xfer_b);
   assign b_gnt   = (r_state == OWN_B);
   assign b_dout  = r_b_dout;
   assign b_valid = r_b_valid;
   assign b_busy  = r_b_busy;
   assign spi_ss  = r_spi_ss;

endmodule
